// File: rtl/multiplier.sv
// Unsigned pipelined array multiplier: operands registered, carry-save row array
// plus final carry-propagate add, product registered (2-edge latency, throughput 1).

module csa_row #(
  parameter int width = 8,
  parameter int shift = 0
) (
  input  logic [width-1:0]   a,
  input  logic               bsel,
  input  logic [2*width-1:0] s_in,
  input  logic [2*width-1:0] c_in,
  output logic [2*width-1:0] s_out,
  output logic [2*width-1:0] c_out
);
  localparam int pw = 2 * width;

  logic [pw-1:0] pp;
  logic [pw-1:0] maj;

  assign pp    = bsel ? (pw'(a) << shift) : '0;
  assign s_out = s_in ^ c_in ^ pp;
  assign maj   = (s_in & c_in) | (s_in & pp) | (c_in & pp);
  // The carry shifted out of the top is always zero in weight: the true sum fits in pw bits.
  assign c_out = maj << 1;
endmodule

module multiplier #(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic [2*width-1:0]   y
);
  localparam int pw = 2 * width;

  logic [width-1:0]          a_q, b_q;
  logic [width:0][pw-1:0]    s, c;
  logic [pw-1:0]             prod;

  assign s[0] = '0;
  assign c[0] = '0;

  generate
    for (genvar i = 0; i < width; i++) begin : g_row
      csa_row #(.width(width), .shift(i)) u_row (
        .a     (a_q),
        .bsel  (b_q[i]),
        .s_in  (s[i]),
        .c_in  (c[i]),
        .s_out (s[i+1]),
        .c_out (c[i+1])
      );
    end
  endgenerate

  assign prod = s[width] + c[width];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      y   <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      y   <= prod;
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench: stimulus pushes expected products with a due edge, monitor pops and compares.

module tb_multiplier;
  typedef struct {
    logic [127:0] e64;
    logic [15:0]  e8;
    logic [7:0]   e4;
    bit           c64, c8, c4;
    int           due;
  } exp_t;

  logic         clk = 0;
  logic         rst_n = 1;
  logic [63:0]  a64 = 0, b64 = 0;
  logic [7:0]   a8 = 0, b8 = 0;
  logic [3:0]   a4 = 0, b4 = 0;
  logic [127:0] y64;
  logic [15:0]  y8;
  logic [7:0]   y4;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  multiplier #(.width(64)) u64 (.clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .y(y64));
  multiplier #(.width(8))  u8  (.clk(clk), .rst_n(rst_n), .a(a8),  .b(b8),  .y(y8));
  multiplier #(.width(4))  u4  (.clk(clk), .rst_n(rst_n), .a(a4),  .b(b4),  .y(y4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] e64, input bit c64,
                              input logic [15:0] e8, input bit c8,
                              input logic [7:0] e4, input bit c4);
    exp_t e;
    e.e64 = e64; e.c64 = c64;
    e.e8  = e8;  e.c8  = c8;
    e.e4  = e4;  e.c4  = c4;
    e.due = 0;
    return e;
  endfunction

  // Called at a negedge after inputs are set: sampled at the next edge, visible one edge later.
  task automatic push(input exp_t e);
    e.due = cyc + 2;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.due < cyc) chk("late_entry", 128'(e.due), 128'(cyc));
        if (e.c64) chk("y64", y64, e.e64);
        if (e.c8)  chk("y8", {112'b0, y8}, {112'b0, e.e8});
        if (e.c4)  chk("y4", {120'b0, y4}, {120'b0, e.e4});
      end
    end
  end

  logic [63:0] x;
  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  initial begin
    // Reset held with live operands
    #1 rst_n = 0;
    a64 = 5; b64 = 7; a8 = 5; b8 = 7; a4 = 5; b4 = 7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_y64", y64, 0);
      chk("rst_y8", {112'b0, y8}, 0);
      chk("rst_y4", {120'b0, y4}, 0);
    end
    rst_n = 1;
    a64 = 3; b64 = 4; a8 = 3; b8 = 4; a4 = 3; b4 = 4;
    push(mk(128'd12, 1, 16'd12, 1, 8'd12, 1));

    // Directed stream: w8 small cases, w64 extremes, w4 corners
    @(negedge clk);
    chk("post_rel_edgeN_y64", y64, 0);
    chk("post_rel_edgeN_y8", {112'b0, y8}, 0);
    a8 = 1; b8 = 1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'hFFFF_FFFF_FFFF_FFFF; a4 = 15; b4 = 15;
    push(mk(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1, 16'd1, 1, 8'd225, 1));
    @(negedge clk);
    a8 = 2; b8 = 3; a64 = 64'h8000_0000_0000_0000; b64 = 2; a4 = 9; b4 = 13;
    push(mk(128'h1_0000_0000_0000_0000, 1, 16'd6, 1, 8'd117, 1));
    @(negedge clk);
    a8 = 255; b8 = 255; a64 = 0; b64 = 64'hDEAD_BEEF_CAFE_F00D; a4 = 0; b4 = 15;
    push(mk(128'd0, 1, 16'd65025, 1, 8'd0, 1));
    @(negedge clk);
    a8 = 0; b8 = 200; a64 = 64'h1_0000_0001; b64 = 64'hFFFF_FFFF; a4 = 15; b4 = 1;
    push(mk(128'hFFFF_FFFF_FFFF_FFFF, 1, 16'd0, 1, 8'd15, 1));

    // Random stream on the 64-bit instance, xorshift seed 11
    x = 64'd11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      x = xs(x); a64 = x;
      x = xs(x); b64 = x;
      a8 = 0; b8 = 0; a4 = 0; b4 = 0;
      push(mk({64'b0, a64} * {64'b0, b64}, 1, 16'd0, 1, 8'd0, 1));
    end

    // Reset with two products in flight
    @(negedge clk);
    a64 = 7; b64 = 9; a8 = 7; b8 = 9;
    push(mk(128'd63, 1, 16'd63, 1, 8'd0, 1));
    @(negedge clk);
    a64 = 11; b64 = 13; a8 = 11; b8 = 13;
    push(mk(128'd143, 1, 16'd143, 1, 8'd0, 1));
    @(posedge clk);
    #3;
    q.delete();
    rst_n = 0;
    #1;
    chk("async_rst_y64", y64, 0);
    chk("async_rst_y8", {112'b0, y8}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_hold_y64", y64, 0);
    end
    rst_n = 1;
    a64 = 2; b64 = 2; a8 = 2; b8 = 2;
    push(mk(128'd4, 1, 16'd4, 1, 8'd0, 1));
    @(negedge clk);
    chk("no_stale_y64", y64, 0);
    chk("no_stale_y8", {112'b0, y8}, 0);
    a64 = 64'd1000; b64 = 64'd1000; a8 = 16; b8 = 16;
    push(mk(128'd1000000, 1, 16'd256, 1, 8'd0, 1));

    // Exhaustive width-4 sweep
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a4 = 4'(i >> 4); b4 = 4'(i);
      a64 = 0; b64 = 0; a8 = 0; b8 = 0;
      push(mk(128'd0, 0, 16'd0, 0, 8'(a4) * 8'(b4), 1));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 128'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
